vga_text_console: RTL and testbench

VGA_TEXT_CONSOLE -- requirements
Module: vga_text_console

---
 rtl/vga_console_pkg.sv | 51 +++++
 rtl/vga_console_cursor.sv | 87 ++++++++
 rtl/vga_text_console.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_vga_text_console.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_console_pkg.sv
// Shared constants, state/command types and VRAM word helpers for vga_text_console.
// Build macro VGA_CONSOLE_SCROLL_EN selects hardware scroll instead of wrap-to-top at the last row.
package vga_console_pkg;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 30;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  localparam int WORD_ASCII_LSB = 0;
  localparam int WORD_BG_LSB    = 8;
  localparam int WORD_FG_LSB    = 20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUT     = 3'd1,
    ST_SCR_RD  = 3'd2,
    ST_SCR_WR  = 3'd3,
    ST_CLR_ROW = 3'd4,
    ST_CLR_ALL = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CUR_NONE = 3'd0,
    CUR_ADV  = 3'd1,
    CUR_CR   = 3'd2,
    CUR_NL   = 3'd3,
    CUR_BS   = 3'd4,
    CUR_HOME = 3'd5
  } cur_op_e;

  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= CH_SPACE) && (ch <= CH_TILDE);
  endfunction

  // attr is {fg, bg}; the VRAM word is {fg, bg, ascii}
  function automatic logic [31:0] vram_word(input logic [23:0] attr, input logic [7:0] ch);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[WORD_FG_LSB +: 12]   = attr[23:12];
    w[WORD_BG_LSB +: 12]   = attr[11:0];
    w[WORD_ASCII_LSB +: 8] = ch;
    return w;
  endfunction

endpackage

// File: rtl/vga_console_cursor.sv
// Cursor column/row registers with advance, newline, carriage return, backspace and home.
module vga_console_cursor
  import vga_console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  cur_op_e    op,
  output logic [6:0] col,
  output logic [4:0] row,
  output logic       at_last_row,
  output logic       at_last_col,
  output logic       col_zero
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  logic [6:0] col_r;
  logic [6:0] col_s;
  logic [4:0] row_r;
  logic [4:0] row_s;

  // Next cursor position; the row never moves past the last row here, scrolling is the caller's job
  always_comb begin
    col_s = col_r;
    row_s = row_r;
    case (op)
      CUR_ADV: begin
        if (col_r == LAST_COL) begin
          col_s = 7'd0;
          if (row_r != LAST_ROW) begin
            row_s = row_r + 5'd1;
          end else begin
            row_s = row_r;
          end
        end else begin
          col_s = col_r + 7'd1;
        end
      end
      CUR_NL: begin
        col_s = 7'd0;
        if (row_r != LAST_ROW) begin
          row_s = row_r + 5'd1;
        end else begin
          row_s = row_r;
        end
      end
      CUR_CR: col_s = 7'd0;
      CUR_BS: begin
        if (col_r != 7'd0) begin
          col_s = col_r - 7'd1;
        end else begin
          col_s = col_r;
        end
      end
      CUR_HOME: begin
        col_s = 7'd0;
        row_s = 5'd0;
      end
      default: begin
        col_s = col_r;
        row_s = row_r;
      end
    endcase
  end

  // Cursor register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_r <= 7'd0;
      row_r <= 5'd0;
    end else begin
      col_r <= col_s;
      row_r <= row_s;
    end
  end

  assign col         = col_r;
  assign row         = row_r;
  assign at_last_row = (row_r == LAST_ROW);
  assign at_last_col = (col_r == LAST_COL);
  assign col_zero    = (col_r == 7'd0);

endmodule

// File: rtl/vga_text_console.sv
// Byte-stream text console writing {fg, bg, ascii} cells into a character VRAM.
// VGA_CONSOLE_SCROLL_EN: defined -> scroll up at the last row; undefined -> wrap to row 0 and clear it.
module vga_text_console
  import vga_console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        chValid,
  input  logic [7:0]  chData,
  output logic        chReady,
  input  logic [23:0] attr,
  output logic        vramEn,
  output logic [3:0]  vramWe,
  output logic [11:0] vramAddr,
  output logic [31:0] vramDout,
  input  logic [31:0] vramDin,
  input  logic [7:0]  blinkFreq,
  output logic [31:0] cursorCtrl,
  output logic        busy
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
`ifdef VGA_CONSOLE_SCROLL_EN
  localparam logic [4:0] PEN_ROW  = 5'(ROWS - 2);
`endif

  state_e      state_r, state_s;
  logic [23:0] attr_r, attr_s;
  logic [4:0]  rr_r, rr_s;
  logic [6:0]  cc_r, cc_s;
  logic        put_adv_r, put_adv_s;
  logic        ready_r;
  logic        en_r, en_s;
  logic [3:0]  we_r, we_s;
  logic [11:0] addr_r, addr_s;
  logic [31:0] dout_r, dout_s;
  logic        din_sel_r, din_sel_s;
  logic [11:0] put_addr_s;
  logic [31:0] put_data_s;
  logic        accept_s;
  logic        last_clr_row_s;
  cur_op_e     cur_op_s;
  logic [6:0]  cur_col_s;
  logic [4:0]  cur_row_s;
  logic        at_last_row_s;
  logic        at_last_col_s;
  logic        col_zero_s;
`ifndef VGA_CONSOLE_SCROLL_EN
  logic        one_row_r, one_row_s;
`endif

  vga_console_cursor #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_cursor (
    .clk        (clk),
    .rstn       (rstn),
    .op         (cur_op_s),
    .col        (cur_col_s),
    .row        (cur_row_s),
    .at_last_row(at_last_row_s),
    .at_last_col(at_last_col_s),
    .col_zero   (col_zero_s)
  );

  assign accept_s = chValid & chReady;

`ifdef VGA_CONSOLE_SCROLL_EN
  assign last_clr_row_s = (rr_r == LAST_ROW);
`else
  assign last_clr_row_s = one_row_r | (rr_r == LAST_ROW);
`endif

  // Next state, cell counters, cursor command, and the VRAM command for the coming cycle
  always_comb begin
    state_s    = state_r;
    attr_s     = attr_r;
    rr_s       = rr_r;
    cc_s       = cc_r;
    put_adv_s  = put_adv_r;
    cur_op_s   = CUR_NONE;
    put_addr_s = 12'h000;
    put_data_s = 32'h0000_0000;
`ifndef VGA_CONSOLE_SCROLL_EN
    one_row_s  = one_row_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          attr_s = attr;
          if (is_printable(chData)) begin
            state_s    = ST_PUT;
            put_adv_s  = 1'b1;
            put_addr_s = {cur_row_s, cur_col_s};
            put_data_s = vram_word(attr, chData);
          end else if (chData == CH_LF) begin
            if (!at_last_row_s) begin
              cur_op_s = CUR_NL;
            end else begin
`ifdef VGA_CONSOLE_SCROLL_EN
              state_s   = ST_SCR_RD;
`else
              state_s   = ST_CLR_ALL;
              one_row_s = 1'b1;
`endif
              rr_s = 5'd0;
              cc_s = 7'd0;
            end
          end else if (chData == CH_CR) begin
            cur_op_s = CUR_CR;
          end else if (chData == CH_BS) begin
            if (!col_zero_s) begin
              cur_op_s   = CUR_BS;
              state_s    = ST_PUT;
              put_adv_s  = 1'b0;
              put_addr_s = {cur_row_s, cur_col_s - 7'd1};
              put_data_s = vram_word(attr, CH_SPACE);
            end else begin
              cur_op_s = CUR_NONE;
            end
          end else if (chData == CH_FF) begin
            state_s   = ST_CLR_ALL;
            rr_s      = 5'd0;
            cc_s      = 7'd0;
`ifndef VGA_CONSOLE_SCROLL_EN
            one_row_s = 1'b0;
`endif
          end else begin
            cur_op_s = CUR_NONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PUT: begin
        state_s = ST_IDLE;
        if (!put_adv_r) begin
          cur_op_s = CUR_NONE;
        end else if (at_last_col_s && at_last_row_s) begin
          // wrap at the bottom-right cell: cursor stays put until the bottom operation ends
`ifdef VGA_CONSOLE_SCROLL_EN
          state_s   = ST_SCR_RD;
`else
          state_s   = ST_CLR_ALL;
          one_row_s = 1'b1;
`endif
          rr_s = 5'd0;
          cc_s = 7'd0;
        end else begin
          cur_op_s = CUR_ADV;
        end
      end
`ifdef VGA_CONSOLE_SCROLL_EN
      ST_SCR_RD: state_s = ST_SCR_WR;
      ST_SCR_WR: begin
        if (cc_r == LAST_COL) begin
          cc_s = 7'd0;
          if (rr_r == PEN_ROW) begin
            state_s = ST_CLR_ROW;
            rr_s    = LAST_ROW;
          end else begin
            state_s = ST_SCR_RD;
            rr_s    = rr_r + 5'd1;
          end
        end else begin
          state_s = ST_SCR_RD;
          cc_s    = cc_r + 7'd1;
        end
      end
      ST_CLR_ROW: begin
        if (cc_r == LAST_COL) begin
          state_s  = ST_IDLE;
          cc_s     = 7'd0;
          cur_op_s = CUR_CR;
        end else begin
          cc_s = cc_r + 7'd1;
        end
      end
`endif
      ST_CLR_ALL: begin
        if (cc_r == LAST_COL) begin
          cc_s = 7'd0;
          if (last_clr_row_s) begin
            state_s  = ST_IDLE;
            rr_s     = 5'd0;
            cur_op_s = CUR_HOME;
          end else begin
            rr_s = rr_r + 5'd1;
          end
        end else begin
          cc_s = cc_r + 7'd1;
        end
      end
      default: state_s = ST_IDLE;
    endcase

    en_s      = 1'b0;
    we_s      = 4'h0;
    addr_s    = 12'h000;
    dout_s    = 32'h0000_0000;
    din_sel_s = 1'b0;
    case (state_s)
      ST_PUT: begin
        en_s   = 1'b1;
        we_s   = 4'hF;
        addr_s = put_addr_s;
        dout_s = put_data_s;
      end
`ifdef VGA_CONSOLE_SCROLL_EN
      ST_SCR_RD: begin
        en_s   = 1'b1;
        we_s   = 4'h0;
        addr_s = {rr_s + 5'd1, cc_s};
      end
      ST_SCR_WR: begin
        en_s      = 1'b1;
        we_s      = 4'hF;
        addr_s    = {rr_s, cc_s};
        din_sel_s = 1'b1;
      end
      ST_CLR_ROW: begin
        en_s   = 1'b1;
        we_s   = 4'hF;
        addr_s = {rr_s, cc_s};
        dout_s = vram_word(attr_s, CH_SPACE);
      end
`endif
      ST_CLR_ALL: begin
        en_s   = 1'b1;
        we_s   = 4'hF;
        addr_s = {rr_s, cc_s};
        dout_s = vram_word(attr_s, CH_SPACE);
      end
      default: begin
        en_s   = 1'b0;
        we_s   = 4'h0;
        addr_s = 12'h000;
        dout_s = 32'h0000_0000;
      end
    endcase
  end

  // State, counters and registered VRAM command
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      attr_r    <= 24'h000000;
      rr_r      <= 5'd0;
      cc_r      <= 7'd0;
      put_adv_r <= 1'b0;
      ready_r   <= 1'b0;
      en_r      <= 1'b0;
      we_r      <= 4'h0;
      addr_r    <= 12'h000;
      dout_r    <= 32'h0000_0000;
      din_sel_r <= 1'b0;
`ifndef VGA_CONSOLE_SCROLL_EN
      one_row_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      attr_r    <= attr_s;
      rr_r      <= rr_s;
      cc_r      <= cc_s;
      put_adv_r <= put_adv_s;
      ready_r   <= 1'b1;
      en_r      <= en_s;
      we_r      <= we_s;
      addr_r    <= addr_s;
      dout_r    <= dout_s;
      din_sel_r <= din_sel_s;
`ifndef VGA_CONSOLE_SCROLL_EN
      one_row_r <= one_row_s;
`endif
    end
  end

  // read data arrives one cycle after the read, so the copy write forwards it directly
  assign vramDout   = din_sel_r ? vramDin : dout_r;
  assign vramEn     = en_r;
  assign vramWe     = we_r;
  assign vramAddr   = addr_r;
  assign chReady    = ready_r & (state_r == ST_IDLE);
  assign busy       = (state_r != ST_IDLE);
  assign cursorCtrl = {8'h00, blinkFreq, 3'b000, cur_row_s, 1'b0, cur_col_s};

endmodule

// File: tb/tb_vga_text_console.sv
// Directed, table-driven bench for vga_text_console with a behavioural 1-cycle-latency VRAM.
module tb_vga_text_console;

  logic        clk = 1'b0;
  logic        rstn;
  logic        chValid;
  logic [7:0]  chData;
  logic        chReady;
  logic [23:0] attr;
  logic        vramEn;
  logic [3:0]  vramWe;
  logic [11:0] vramAddr;
  logic [31:0] vramDout;
  logic [31:0] vramDin;
  logic [7:0]  blinkFreq;
  logic [31:0] cursorCtrl;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vga_text_console dut (
    .clk       (clk),
    .rstn      (rstn),
    .chValid   (chValid),
    .chData    (chData),
    .chReady   (chReady),
    .attr      (attr),
    .vramEn    (vramEn),
    .vramWe    (vramWe),
    .vramAddr  (vramAddr),
    .vramDout  (vramDout),
    .vramDin   (vramDin),
    .blinkFreq (blinkFreq),
    .cursorCtrl(cursorCtrl),
    .busy      (busy)
  );

  logic [31:0] ram [0:4095];
  logic [31:0] rdata = 32'h0;
  logic        fill_go = 1'b0;
  int          wr_count = 0;
  int          hs_count = 0;
  logic [11:0] last_waddr = 12'h0;
  logic [31:0] last_wdata = 32'h0;

  assign vramDin = rdata;

  always @(posedge clk) begin
    if (fill_go) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 32'hC0DE0000 | 32'(i);
    end else if (vramEn) begin
      if (vramWe == 4'hF) begin
        ram[vramAddr] <= vramDout;
        wr_count      <= wr_count + 1;
        last_waddr    <= vramAddr;
        last_wdata    <= vramDout;
      end else begin
        rdata <= ram[vramAddr];
      end
    end
    if (chValid && chReady) hs_count <= hs_count + 1;
  end

  function automatic logic [31:0] pat(input int r, input int c);
    return 32'hC0DE0000 | (32'(r) << 7) | 32'(c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_ram();
    @(negedge clk); fill_go = 1'b1;
    @(negedge clk); fill_go = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic [23:0] a);
    int n;
    n = 0;
    @(negedge clk);
    chValid = 1'b1; chData = d; attr = a;
    while (!chReady && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (!chReady) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: byte %h never accepted", d);
    end
    @(posedge clk);
    #1 chValid = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (busy && cycles < 6000) begin
      cycles++;
      @(negedge clk);
    end
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, cycles);
    end
  endtask

  typedef struct {
    logic [7:0]  ch;
    logic [23:0] at;
    int          n_wr;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [6:0]  col;
    logic [4:0]  row;
  } vec_t;

  vec_t vecs [13];

`ifdef VGA_CONSOLE_SCROLL_EN
  localparam int EXP_BUSY = 4720;
  localparam int END_ROW  = 29;
`else
  localparam int EXP_BUSY = 80;
  localparam int END_ROW  = 0;
`endif

  initial begin
    int w0, h0, cyc, errs, busy_cyc, idx, r, c;
    logic [31:0] exp_w;

    vecs[0]  = '{8'h42, 24'h123456, 1, 12'h001, 32'h12345642, 7'd2, 5'd0};
    vecs[1]  = '{8'h0D, 24'h000000, 0, 12'h000, 32'h0,        7'd0, 5'd0};
    vecs[2]  = '{8'h0A, 24'h000000, 0, 12'h000, 32'h0,        7'd0, 5'd1};
    vecs[3]  = '{8'h07, 24'h000000, 0, 12'h000, 32'h0,        7'd0, 5'd1};
    vecs[4]  = '{8'h08, 24'h777777, 0, 12'h000, 32'h0,        7'd0, 5'd1};
    vecs[5]  = '{8'h7A, 24'hABCDEF, 1, 12'h080, 32'hABCDEF7A, 7'd1, 5'd1};
    vecs[6]  = '{8'h08, 24'h0F00F0, 1, 12'h080, 32'h0F00F020, 7'd0, 5'd1};
    vecs[7]  = '{8'h7E, 24'h000FFF, 1, 12'h080, 32'h000FFF7E, 7'd1, 5'd1};
    vecs[8]  = '{8'h7F, 24'h000000, 0, 12'h000, 32'h0,        7'd1, 5'd1};
    vecs[9]  = '{8'h1F, 24'h000000, 0, 12'h000, 32'h0,        7'd1, 5'd1};
    vecs[10] = '{8'h20, 24'h111222, 1, 12'h081, 32'h11122220, 7'd2, 5'd1};
    vecs[11] = '{8'h0A, 24'h000000, 0, 12'h000, 32'h0,        7'd0, 5'd2};
    vecs[12] = '{8'h80, 24'h000000, 0, 12'h000, 32'h0,        7'd0, 5'd2};

    rstn = 1'b0; chValid = 1'b0; chData = 8'h00; attr = 24'h0; blinkFreq = 8'h5A;
    #12;
    chk("rst_vramEn", 32'(vramEn), 32'h0);
    chk("rst_vramWe", 32'(vramWe), 32'h0);
    chk("rst_vramAddr", 32'(vramAddr), 32'h0);
    chk("rst_vramDout", vramDout, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_chReady", 32'(chReady), 32'h0);
    chk("rst_cursorCtrl", cursorCtrl, 32'h005A0000);
    fill_ram();
    @(negedge clk); rstn = 1'b1;
    #1 chk("ready_before_edge", 32'(chReady), 32'h0);
    @(posedge clk);
    #1 chk("ready_after_edge", 32'(chReady), 32'h1);

    // 'A' with write-latency check
    @(negedge clk);
    w0 = wr_count;
    chValid = 1'b1; chData = 8'h41; attr = 24'hFFF000;
    @(posedge clk);
    #1 chValid = 1'b0;
    chk("put_en", 32'(vramEn), 32'h1);
    chk("put_we", 32'(vramWe), 32'hF);
    chk("put_addr", 32'(vramAddr), 32'h000);
    chk("put_dout", vramDout, 32'hFFF00041);
    chk("put_busy", 32'(busy), 32'h1);
    chk("put_ready", 32'(chReady), 32'h0);
    @(posedge clk);
    #1 chk("put_done_en", 32'(vramEn), 32'h0);
    chk("put_done_col", 32'(cursorCtrl[6:0]), 32'h1);
    chk("put_done_wr", 32'(wr_count - w0), 32'h1);
    chk("put_done_data", last_wdata, 32'hFFF00041);

    for (int i = 0; i < 13; i++) begin
      w0 = wr_count;
      send(vecs[i].ch, vecs[i].at);
      wait_idle(cyc);
      chk($sformatf("vec%0d_nwr", i), 32'(wr_count - w0), 32'(vecs[i].n_wr));
      if (vecs[i].n_wr > 0) begin
        chk($sformatf("vec%0d_addr", i), 32'(last_waddr), 32'(vecs[i].waddr));
        chk($sformatf("vec%0d_data", i), last_wdata, vecs[i].wdata);
      end
      chk($sformatf("vec%0d_cursor", i), cursorCtrl,
          {8'h00, 8'h5A, 3'b000, vecs[i].row, 1'b0, vecs[i].col});
    end

    // 80 printable bytes from home wrap onto row 1
    pulse_reset();
    chk("home_after_reset", cursorCtrl, 32'h005A0000);
    w0 = wr_count;
    for (int i = 0; i < 80; i++) begin
      send(8'h78, 24'h00F0F0);
      wait_idle(cyc);
    end
    chk("wrap_nwr", 32'(wr_count - w0), 32'd80);
    chk("wrap_last_addr", 32'(last_waddr), 32'h04F);
    chk("wrap_last_data", last_wdata, 32'h00F0F078);
    chk("wrap_cursor", cursorCtrl, 32'h005A0100);

    // backspace at column 0 and at column 4
    send(8'h0A, 24'h0); wait_idle(cyc);
    send(8'h0A, 24'h0); wait_idle(cyc);
    w0 = wr_count;
    send(8'h08, 24'hAAA555); wait_idle(cyc);
    chk("bs_col0_nwr", 32'(wr_count - w0), 32'h0);
    chk("bs_col0_cursor", cursorCtrl, 32'h005A0300);
    for (int i = 0; i < 4; i++) begin
      send(8'h61, 24'h0); wait_idle(cyc);
    end
    w0 = wr_count;
    send(8'h08, 24'hAAA555); wait_idle(cyc);
    chk("bs_nwr", 32'(wr_count - w0), 32'h1);
    chk("bs_addr", 32'(last_waddr), 32'h183);
    chk("bs_data", last_wdata, 32'hAAA55520);
    chk("bs_cursor", cursorCtrl, 32'h005A0303);

    // newline on the last row with chValid held through the whole operation
    pulse_reset();
    fill_ram();
    for (int i = 0; i < 29; i++) begin
      send(8'h0A, 24'h0); wait_idle(cyc);
    end
    chk("row29_cursor", cursorCtrl, 32'h005A1D00);
    for (int i = 0; i < 5; i++) begin
      send(8'h71, 24'h000000); wait_idle(cyc);
    end
    h0 = hs_count;
    @(negedge clk);
    chValid = 1'b1; chData = 8'h0A; attr = 24'h456789;
    @(posedge clk);
    #1 chData = 8'h4B; attr = 24'h0A0B0C;
    busy_cyc = 0;
    @(negedge clk);
    while (busy && busy_cyc < 6000) begin
      busy_cyc++;
      if (busy_cyc == EXP_BUSY / 2) chk("cursor_hold", cursorCtrl, 32'h005A1D05);
      @(negedge clk);
    end
    @(posedge clk);
    #1 chValid = 1'b0;
    wait_idle(cyc);
    chk("bottom_busy_cycles", 32'(busy_cyc), 32'(EXP_BUSY));
    chk("held_valid_handshakes", 32'(hs_count - h0), 32'd2);
    chk("next_byte_addr", 32'(last_waddr), 32'(END_ROW << 7));
    chk("next_byte_data", last_wdata, 32'h0A0B0C4B);
    chk("bottom_cursor", cursorCtrl, 32'h005A0001 | (32'(END_ROW) << 8));
    errs = 0;
    for (r = 0; r < 30; r++) begin
      for (c = 0; c < 80; c++) begin
`ifdef VGA_CONSOLE_SCROLL_EN
        if (r < 28) exp_w = pat(r + 1, c);
        else if (r == 28) exp_w = (c < 5) ? 32'h00000071 : pat(29, c);
        else exp_w = (c == 0) ? 32'h0A0B0C4B : 32'h45678920;
`else
        if (r == 0) exp_w = (c == 0) ? 32'h0A0B0C4B : 32'h45678920;
        else if (r == 29) exp_w = (c < 5) ? 32'h00000071 : pat(29, c);
        else exp_w = pat(r, c);
`endif
        if (ram[(r << 7) | c] !== exp_w) errs++;
      end
    end
    chk("bottom_vram_cells_wrong", 32'(errs), 32'h0);

    // form feed abandoned by reset after 100 cycles
    pulse_reset();
    fill_ram();
    @(negedge clk);
    chValid = 1'b1; chData = 8'h0C; attr = 24'h321CBA;
    @(posedge clk);
    #1 chValid = 1'b0;
    repeat (100) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_en", 32'(vramEn), 32'h0);
    chk("abort_we", 32'(vramWe), 32'h0);
    chk("abort_addr", 32'(vramAddr), 32'h0);
    chk("abort_dout", vramDout, 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_ready", 32'(chReady), 32'h0);
    chk("abort_cursor", cursorCtrl, 32'h005A0000);
    @(negedge clk);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk);
    #1 chk("abort_ready_after", 32'(chReady), 32'h1);
    errs = 0;
    for (idx = 0; idx < 2400; idx++) begin
      r = idx / 80;
      c = idx % 80;
      if (idx < 99) exp_w = 32'h321CBA20;
      else exp_w = pat(r, c);
      if (idx != 99 && ram[(r << 7) | c] !== exp_w) errs++;
    end
    chk("ff_abort_cells_wrong", 32'(errs), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
